gate_truth_checker: RTL
=======================

// Module: gate_truth_checker
// PURPOSE
// On-chip response checker for the two-input logic-gate block.
// - Drives the gate block's A/B inputs through all four combinations (00, 01, 10, 11).
// - Samples the 8-bit gate output and compares it with the expected truth table.
// - Latches sticky per-output failure bits and a failing-vector count.
// - Reports a pass/fail verdict, so the gate block can be proven in silicon without external pattern equipment.
// PARAMETERS
// SETTLE_CYCLES  1  cycles stimulus is held before sampling; legal values 1..255
// PASSES         1  number of full 4-vector sweeps per run; legal values 1..255
// PORTS
// clk        in   1  system clock
// rst_n      in   1  asynchronous active-low reset
// ena        in   1  1 = FSM advances; 0 = all state and outputs frozen
// start      in   1  level sampled on clk; starts a run from IDLE or DONE
// dut_out    in   8  gate outputs: [0]AND [1]OR [2]XOR [3]NAND [4]NOR [5]XNOR [6]NOT A [7]NOT B
// stim_a     out  1  A input to the gate block (registered)
// stim_b     out  1  B input to the gate block (registered)
// busy       out  1  run in progress (state DRIVE, SETTLE or CHECK)
// done       out  1  run complete; held until the next accepted start or reset
// pass       out  1  done & (fail_mask == 0)
// fail_mask  out  8  sticky: bit i set if dut_out[i] mismatched on any checked vector
// err_count  out  8  number of checked vectors with any mismatch; saturates at 255
// BEHAVIOUR
// Reset (async assert, sync release): state IDLE.
// - All outputs are 0, including stim_a, stim_b, fail_mask and err_count.
// - Reset asserted mid-run aborts immediately; no partial verdict is kept.
// States: IDLE, DRIVE, SETTLE, CHECK, DONE. All transitions require ena=1.
// - ena=0 holds the state, counters and outputs unchanged.
// IDLE or DONE with start=1 -> DRIVE.
// - On that edge: clear fail_mask, err_count and done; reset the vector index and pass counter to 0.
// DRIVE (1 cycle):
// - stim_a/stim_b were loaded from the vector index on the edge that entered DRIVE.
// - Order: idx0 = (a=0,b=0), idx1 = (0,1), idx2 = (1,0), idx3 = (1,1).
// - Next state: SETTLE, with the settle counter set to SETTLE_CYCLES.
// SETTLE (SETTLE_CYCLES cycles):
// - Decrement the settle counter each cycle; go to CHECK after the last one.
// CHECK (1 cycle): on the exit edge, compare dut_out with exp.
// - exp = {~b, ~a, ~(a^b), ~(a|b), ~(a&b), a^b, a|b, a&b}.
// - fail_mask |= dut_out ^ exp.
// - If (dut_out ^ exp) != 0, increment err_count, saturating at 255.
// - Next state: DRIVE with the next vector loaded into stim_a/stim_b.
// - idx3 wraps to idx0 and increments the pass counter.
// - After idx3 of pass PASSES-1, go to DONE instead.
// DONE:
// - done=1, busy=0; stim_a/stim_b hold the last vector.
// - fail_mask and err_count hold their values.
// Latency: done rises 4*PASSES*(SETTLE_CYCLES+2) edges after the edge that accepted start.
// - With default parameters that is 12 edges.
// start while busy is ignored; start is not required to be a pulse.
// - In DONE, a start held high restarts on every completion.
// dut_out is treated as combinational from stim_a/stim_b.
// - It is not sampled outside the CHECK exit edge, so X on dut_out in other states is harmless.
// TESTING
// 1. Correct gate model, default parameters, start for 1 cycle:
//    -> stim steps 00,01,10,11; done at +12 edges; pass=1; fail_mask=8'h00; err_count=0.
// 2. dut_out[2] (XOR) stuck at 0:
//    -> pass=0; fail_mask=8'h04; err_count=2 (vectors 01 and 10).
// 3. dut_out[0] (AND) stuck at 1, PASSES=3, SETTLE_CYCLES=4:
//    -> done at +72 edges; fail_mask=8'h01; err_count=9.
// 4. ena low for 5 cycles during SETTLE of idx1:
//    -> stim, busy and counters frozen; done delayed by exactly 5 edges; verdict unchanged.
// 5. rst_n low during CHECK of idx2 after a mismatch:
//    -> all outputs 0 immediately; the next start gives a clean run with err_count reflecting only the new run.
// 6. start pulsed while busy:
//    -> ignored, timing unchanged.
//    start in DONE after a failing run with a now-correct model:
//    -> fail_mask/err_count clear on accept; final pass=1.

Source files
------------

// File: rtl/gate_truth_checker.sv
// gate_truth_checker: built-in response checker for the two-input logic-gate block.
// Sweeps A/B through 00,01,10,11 for PASSES sweeps. Checks the 8 gate outputs against
// the truth table, then reports sticky per-output failures, a failing-vector count
// and a pass/fail verdict.
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] dut_out,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_mask,
  output logic [7:0] err_count
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned GATE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic [CNT_W-1:0]   r_pass_cnt;
  logic [CNT_W-1:0]   w_pass_cnt_nxt;
  logic [CNT_W-1:0]   r_settle;
  logic [CNT_W-1:0]   w_settle_nxt;
  logic               r_stim_a;
  logic               w_stim_a_nxt;
  logic               r_stim_b;
  logic               w_stim_b_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               r_done;
  logic               w_done_nxt;
  logic               r_pass;
  logic               w_pass_nxt;
  logic [GATE_W-1:0]  r_fail_mask;
  logic [GATE_W-1:0]  w_fail_mask_nxt;
  logic [CNT_W-1:0]   r_err_count;
  logic [CNT_W-1:0]   w_err_count_nxt;

  logic [GATE_W-1:0]  w_exp;
  logic [GATE_W-1:0]  w_diff;
  logic               w_last_vec;
  logic [IDX_W-1:0]   w_idx_inc;

  // Expected gate response for the vector currently driven
  always_comb begin
    w_exp = {~r_stim_b, ~r_stim_a, ~(r_stim_a ^ r_stim_b), ~(r_stim_a | r_stim_b),
             ~(r_stim_a & r_stim_b), r_stim_a ^ r_stim_b, r_stim_a | r_stim_b,
             r_stim_a & r_stim_b};
    w_diff     = dut_out ^ w_exp;
    w_last_vec = (r_idx == 2'd3) && (r_pass_cnt == CNT_W'(PASSES - 1));
    w_idx_inc  = r_idx + 2'd1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; every transition is qualified by ena
  always_comb begin
    w_state_nxt = r_state;
    if (ena) begin
      case (r_state)
        S_IDLE, S_DONE: if (start) w_state_nxt = S_DRIVE;
        S_DRIVE:        w_state_nxt = S_SETTLE;
        S_SETTLE:       if (r_settle <= CNT_W'(1)) w_state_nxt = S_CHECK;
        S_CHECK:        w_state_nxt = w_last_vec ? S_DONE : S_DRIVE;
        default:        w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Next values of counters, stimulus and verdict; holding is the default
  always_comb begin
    w_idx_nxt       = r_idx;
    w_pass_cnt_nxt  = r_pass_cnt;
    w_settle_nxt    = r_settle;
    w_stim_a_nxt    = r_stim_a;
    w_stim_b_nxt    = r_stim_b;
    w_done_nxt      = r_done;
    w_fail_mask_nxt = r_fail_mask;
    w_err_count_nxt = r_err_count;
    if (ena) begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_idx_nxt       = '0;
            w_pass_cnt_nxt  = '0;
            w_stim_a_nxt    = 1'b0;
            w_stim_b_nxt    = 1'b0;
            w_done_nxt      = 1'b0;
            w_fail_mask_nxt = '0;
            w_err_count_nxt = '0;
          end
        end
        S_DRIVE: begin
          w_settle_nxt = CNT_W'(SETTLE_CYCLES);
        end
        S_SETTLE: begin
          w_settle_nxt = r_settle - CNT_W'(1);
        end
        S_CHECK: begin
          w_fail_mask_nxt = r_fail_mask | w_diff;
          if ((w_diff != '0) && (r_err_count != 8'hFF)) begin
            w_err_count_nxt = r_err_count + CNT_W'(1);
          end
          if (w_last_vec) begin
            w_done_nxt = 1'b1;
          end else begin
            // idx0..3 map to (a,b) = 00,01,10,11
            w_idx_nxt    = w_idx_inc;
            w_stim_a_nxt = w_idx_inc[1];
            w_stim_b_nxt = w_idx_inc[0];
            if (r_idx == 2'd3) begin
              w_pass_cnt_nxt = r_pass_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          w_done_nxt = r_done;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt == S_DRIVE) || (w_state_nxt == S_SETTLE) ||
                 (w_state_nxt == S_CHECK);
    w_pass_nxt = w_done_nxt && (w_fail_mask_nxt == '0);
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_pass_cnt  <= '0;
      r_settle    <= '0;
      r_stim_a    <= 1'b0;
      r_stim_b    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_fail_mask <= '0;
      r_err_count <= '0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_pass_cnt  <= w_pass_cnt_nxt;
      r_settle    <= w_settle_nxt;
      r_stim_a    <= w_stim_a_nxt;
      r_stim_b    <= w_stim_b_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_pass      <= w_pass_nxt;
      r_fail_mask <= w_fail_mask_nxt;
      r_err_count <= w_err_count_nxt;
    end
  end

  assign stim_a    = r_stim_a;
  assign stim_b    = r_stim_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_mask = r_fail_mask;
  assign err_count = r_err_count;

endmodule
